// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, bus field
// layouts (as packed structs, MSB first), mem_size encodings, mul/div select
// bit indices and the CSR index of TLBEHI.
package mem_stage_pkg;

  localparam int ES_TO_MS_WD = 215;
  localparam int MS_TO_WS_WD = 168;
  localparam int FWD_WD      = 39;

  // forward bus: {dep_need_stall, forward_enable, dest[4:0], result[31:0]}
  localparam int FWD_RESULT_LSB = 0;
  localparam int FWD_DEST_LSB   = 32;
  localparam int FWD_EN_BIT     = 37;
  localparam int FWD_STALL_BIT  = 38;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b01;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b10;

  localparam int MD_MUL_LO = 0;
  localparam int MD_MUL_HI = 1;
  localparam int MD_DIV    = 2;
  localparam int MD_MOD    = 3;

  localparam logic [13:0] CSR_TLBEHI = 14'h011;

  typedef struct packed {
    logic        idle;
    logic        refetch;
    logic        tlbsrch;
    logic        tlbwr;
    logic        tlbfill;
    logic        tlbrd;
    logic        invtlb;
    logic [31:0] error_va;
    logic [31:0] csr_result;
    logic [13:0] csr_idx;
    logic        csr_we;
    logic        ertn;
    logic [9:0]  excp_num;
    logic        excp;
    logic [31:0] csr_wmask;
    logic [2:0]  rsvd;
    logic        sc_w;
    logic        dcacop;
    logic        preld_inst;
    logic [3:0]  mul_div_op;
    logic        load_op;
    logic        store_op;
    logic [1:0]  mem_size;
    logic        mem_sign_exted;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        idle;
    logic        refetch;
    logic        tlbsrch;
    logic        tlbwr;
    logic        tlbfill;
    logic        tlbrd;
    logic        invtlb;
    logic [31:0] error_va;
    logic [31:0] csr_result;
    logic [13:0] csr_idx;
    logic        csr_we;
    logic        ertn;
    logic [9:0]  excp_num;
    logic        excp;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake and data-cache response signals around the memory stage.
// master: the surrounding pipeline (execute, writeback, dcache); slave: mem_stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                   es_to_ms_valid;
  logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
  logic                   ms_allowin;
  logic                   ms_to_ws_valid;
  logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
  logic                   ws_allowin;
  logic                   data_data_ok;
  logic [31:0]            data_rdata;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );

endinterface

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half out of the 32-bit
// read word and sign- or zero-extends it; words pass through.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // select the addressed lane, then extend according to access size
  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_SIZE_BYTE: value = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      MEM_SIZE_HALF: value = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:       value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute payload, waits for the
// dcache data_ok of its memory access, aligns load data, selects the final
// result and drives the writeback bus, decode forward bus and hazard flags.
// Build option MS_LOAD_FORWARD_EN: when defined, a load stops stalling decode
// in its data_ok cycle; otherwise decode stalls for the load's whole residency.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_stage_if.slave        pipe,
  output logic [FWD_WD-1:0] ms_to_ds_forward_bus,
  output logic              ms_to_ds_valid,
  input  logic [63:0]       mul_result,
  input  logic [31:0]       div_result,
  input  logic [31:0]       mod_result,
  input  logic              llbit,
  input  logic              excp_flush,
  input  logic              ertn_flush,
  input  logic              refetch_flush,
  input  logic              icacop_flush,
  input  logic              idle_flush,
  output logic              ms_flush,
  output logic              ms_wr_tlbehi
);

  es_to_ms_t   ms_r;
  ms_to_ws_t   wb;
  logic        ms_valid;
  logic        discard;
  logic        data_got;
  logic [31:0] load_r;
  logic [31:0] load_aligned;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        flush_any;
  logic        need_data;
  logic        data_accept;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        forward_enable;
  logic        dep_need_stall;
  logic        unused_es;

  assign unused_es = ^{ms_r.csr_wmask, ms_r.rsvd};

  assign flush_any   = excp_flush | ertn_flush | refetch_flush | icacop_flush | idle_flush;
  assign need_data   = ms_valid && !ms_r.excp &&
                       (ms_r.load_op || ms_r.store_op || ms_r.dcacop || ms_r.preld_inst);
  // data_got makes data_ok a one-shot per instruction, so a stalled
  // writeback does not need the dcache to repeat its response
  assign data_accept = need_data && !data_got && pipe.data_data_ok && !discard;
  assign ms_ready_go = !need_data || data_got || data_accept;
  assign ms_allowin  = !ms_valid || (ms_ready_go && pipe.ws_allowin);

  assign pipe.ms_allowin     = ms_allowin;
  assign pipe.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_to_ds_valid      = ms_valid;

  // stage occupancy
  always_ff @(posedge clk) begin
    if (reset)          ms_valid <= 1'b0;
    else if (flush_any) ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= pipe.es_to_ms_valid;
  end

  // execute payload register
  always_ff @(posedge clk) begin
    if (reset)                                  ms_r <= '0;
    else if (pipe.es_to_ms_valid && ms_allowin) ms_r <= pipe.es_to_ms_bus;
  end

  // remember the accepted response so the result holds while writeback stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      data_got <= 1'b0;
      load_r   <= '0;
    end else if (ms_allowin) begin
      data_got <= 1'b0;
    end else if (data_accept) begin
      data_got <= 1'b1;
      load_r   <= load_aligned;
    end
  end

  // a flushed request is still in flight: swallow its data_ok when it arrives
  always_ff @(posedge clk) begin
    if (reset)
      discard <= 1'b0;
    else if (flush_any && need_data && !data_got && !(pipe.data_data_ok && !discard))
      discard <= 1'b1;
    else if (discard && pipe.data_data_ok)
      discard <= 1'b0;
  end

  mem_load_align u_load_align (
    .rdata    (pipe.data_rdata),
    .offset   (ms_r.exe_result[1:0]),
    .size     (ms_r.mem_size),
    .sign_ext (ms_r.mem_sign_exted),
    .value    (load_aligned)
  );

  assign load_data = data_got ? load_r : load_aligned;

  // result priority: load, sc.w, mul lo/hi, div, mod, execute result
  always_comb begin
    final_result = ms_r.exe_result;
    if (ms_r.load_op)                    final_result = load_data;
    else if (ms_r.sc_w)                  final_result = {31'b0, llbit};
    else if (ms_r.mul_div_op[MD_MUL_LO]) final_result = mul_result[31:0];
    else if (ms_r.mul_div_op[MD_MUL_HI]) final_result = mul_result[63:32];
    else if (ms_r.mul_div_op[MD_DIV])    final_result = div_result;
    else if (ms_r.mul_div_op[MD_MOD])    final_result = mod_result;
  end

  // writeback bus assembly; exception info passes straight through
  always_comb begin
    wb              = '0;
    wb.idle         = ms_r.idle;
    wb.refetch      = ms_r.refetch;
    wb.tlbsrch      = ms_r.tlbsrch;
    wb.tlbwr        = ms_r.tlbwr;
    wb.tlbfill      = ms_r.tlbfill;
    wb.tlbrd        = ms_r.tlbrd;
    wb.invtlb       = ms_r.invtlb;
    wb.error_va     = ms_r.error_va;
    wb.csr_result   = ms_r.csr_result;
    wb.csr_idx      = ms_r.csr_idx;
    wb.csr_we       = ms_r.csr_we;
    wb.ertn         = ms_r.ertn;
    wb.excp_num     = ms_r.excp_num;
    wb.excp         = ms_r.excp;
    wb.gr_we        = ms_r.gr_we;
    wb.dest         = ms_r.dest;
    wb.final_result = final_result;
    wb.pc           = ms_r.pc;
  end

  assign pipe.ms_to_ws_bus = wb;

  assign forward_enable = ms_r.gr_we && (ms_r.dest != 5'd0) && ms_valid;
`ifdef MS_LOAD_FORWARD_EN
  assign dep_need_stall = ms_r.load_op && !pipe.ms_to_ws_valid;
`else
  assign dep_need_stall = ms_r.load_op && ms_valid;
`endif

  assign ms_to_ds_forward_bus = {dep_need_stall, forward_enable, ms_r.dest, final_result};

  // hazards seen by execute: side-effect ops block younger dcache requests,
  // TLBEHI writers and tlbrd hold off tlbsrch
  assign ms_flush = ms_valid && (ms_r.excp || ms_r.ertn || ms_r.csr_we || ms_r.refetch ||
                                 ms_r.tlbsrch || ms_r.tlbwr || ms_r.tlbfill || ms_r.tlbrd ||
                                 ms_r.invtlb || ms_r.idle);
  assign ms_wr_tlbehi = ms_valid && ((ms_r.csr_we && ms_r.csr_idx == CSR_TLBEHI) || ms_r.tlbrd);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads and result-select ops, compared against a behavioural model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk;
  logic              reset;
  logic [FWD_WD-1:0] fwd;
  logic              ms_to_ds_valid;
  logic [63:0]       mul_result;
  logic [31:0]       div_result;
  logic [31:0]       mod_result;
  logic              llbit;
  logic              excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
  logic              ms_flush, ms_wr_tlbehi;
  int                checks = 0;
  int                failures = 0;

  mem_stage_if pipe();

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .pipe                 (pipe),
    .ms_to_ds_forward_bus (fwd),
    .ms_to_ds_valid       (ms_to_ds_valid),
    .mul_result           (mul_result),
    .div_result           (div_result),
    .mod_result           (mod_result),
    .llbit                (llbit),
    .excp_flush           (excp_flush),
    .ertn_flush           (ertn_flush),
    .refetch_flush        (refetch_flush),
    .icacop_flush         (icacop_flush),
    .idle_flush           (idle_flush),
    .ms_flush             (ms_flush),
    .ms_wr_tlbehi         (ms_wr_tlbehi)
  );

  ms_to_ws_t wb;
  logic      fwd_stall, fwd_en;
  assign wb        = pipe.ms_to_ws_bus;
  assign fwd_stall = fwd[FWD_STALL_BIT];
  assign fwd_en    = fwd[FWD_EN_BIT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input es_to_ms_t b);
    pipe.es_to_ms_valid = 1'b1;
    pipe.es_to_ms_bus   = b;
    step();
    pipe.es_to_ms_valid = 1'b0;
  endtask

  function automatic es_to_ms_t alu_op(input logic [31:0] pc);
    es_to_ms_t b;
    b            = '0;
    b.pc         = pc;
    b.exe_result = $urandom;
    b.gr_we      = 1'b1;
    b.dest       = 5'($urandom_range(1, 31));
    return b;
  endfunction

  function automatic es_to_ms_t ld_op(input logic [31:0] pc, input logic [1:0] off,
                                      input logic [1:0] sz, input logic sg);
    es_to_ms_t b;
    b                 = alu_op(pc);
    b.load_op         = 1'b1;
    b.exe_result[1:0] = off;
    b.mem_size        = sz;
    b.mem_sign_exted  = sg;
    return b;
  endfunction

  // load value from byte address arithmetic on the read word
  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'b01) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b10) begin
      v = (rd >> (off[1] ? 16 : 0)) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_result(input es_to_ms_t b, input logic [31:0] rd,
                                             input logic [63:0] mr, input logic [31:0] dr,
                                             input logic [31:0] md, input logic ll);
    if (b.load_op)       return exp_load(rd, b.exe_result[1:0], b.mem_size, b.mem_sign_exted);
    if (b.sc_w)          return {31'b0, ll};
    if (b.mul_div_op[0]) return mr[31:0];
    if (b.mul_div_op[1]) return mr[63:32];
    if (b.mul_div_op[2]) return dr;
    if (b.mul_div_op[3]) return md;
    return b.exe_result;
  endfunction

  task automatic test_reset();
    es_to_ms_t b;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL reset_ws_valid got=%b exp=0", pipe.ms_to_ws_valid); end
    checks++; if (ms_flush !== 1'b0) begin failures++; $display("FAIL reset_ms_flush got=%b exp=0", ms_flush); end
    checks++; if (ms_wr_tlbehi !== 1'b0) begin failures++; $display("FAIL reset_wr_tlbehi got=%b exp=0", ms_wr_tlbehi); end
    checks++; if (fwd_en !== 1'b0) begin failures++; $display("FAIL reset_fwd_en got=%b exp=0", fwd_en); end
    checks++; if (pipe.ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", pipe.ms_allowin); end
    step();
    pipe.ws_allowin = 1'b0;
    b = alu_op(32'h1c00_0000);
    issue(b);
    @(negedge clk);
    checks++; if (ms_to_ds_valid !== 1'b1) begin failures++; $display("FAIL held_valid got=%b exp=1", ms_to_ds_valid); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pipe.ws_allowin = 1'b1;
    @(negedge clk);
    checks++; if (ms_to_ds_valid !== 1'b0) begin failures++; $display("FAIL reset_clears_valid got=%b exp=0", ms_to_ds_valid); end
    step();
  endtask

  task automatic test_load_byte();
    es_to_ms_t b;
    logic      exp_stall_ok;
`ifdef MS_LOAD_FORWARD_EN
    exp_stall_ok = 1'b0;
`else
    exp_stall_ok = 1'b1;
`endif
    b = ld_op(32'h1c00_0100, 2'b11, MEM_SIZE_BYTE, 1'b1);
    issue(b);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (pipe.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL ldb_wait_valid cyc=%0d got=%b exp=0", c, pipe.ms_to_ws_valid); end
      checks++; if (fwd_stall !== 1'b1) begin failures++; $display("FAIL ldb_wait_stall cyc=%0d got=%b exp=1", c, fwd_stall); end
      step();
    end
    pipe.data_data_ok = 1'b1;
    pipe.data_rdata   = 32'h8000_0000;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL ldb_ok_valid got=%b exp=1", pipe.ms_to_ws_valid); end
    checks++; if (wb.final_result !== 32'hFFFF_FF80) begin failures++; $display("FAIL ldb_result got=%h exp=ffffff80", wb.final_result); end
    checks++; if (wb.pc !== b.pc || wb.dest !== b.dest) begin failures++; $display("FAIL ldb_pc_dest got=%h/%0d exp=%h/%0d", wb.pc, wb.dest, b.pc, b.dest); end
    checks++; if (fwd_en !== 1'b1) begin failures++; $display("FAIL ldb_fwd_en got=%b exp=1", fwd_en); end
    checks++; if (fwd_stall !== exp_stall_ok) begin failures++; $display("FAIL ldb_ok_stall got=%b exp=%b", fwd_stall, exp_stall_ok); end
    step();
    pipe.data_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b0 || ms_to_ds_valid !== 1'b0) begin failures++; $display("FAIL ldb_after got=%b/%b exp=0/0", pipe.ms_to_ws_valid, ms_to_ds_valid); end
    step();
  endtask

  task automatic test_load_half();
    es_to_ms_t b;
    b = ld_op(32'h1c00_0200, 2'b10, MEM_SIZE_HALF, 1'b0);
    issue(b);
    pipe.data_data_ok = 1'b1;
    pipe.data_rdata   = 32'hBEEF_1234;
    @(negedge clk);
    checks++; if (wb.final_result !== 32'h0000_BEEF || pipe.ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL ldhu_result got=%h v=%b exp=0000beef v=1", wb.final_result, pipe.ms_to_ws_valid); end
    step();
    pipe.data_data_ok = 1'b0;
    b = ld_op(32'h1c00_0204, 2'b00, MEM_SIZE_HALF, 1'b1);
    issue(b);
    pipe.data_data_ok = 1'b1;
    @(negedge clk);
    checks++; if (wb.final_result !== 32'h0000_1234 || pipe.ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL ldh_result got=%h v=%b exp=00001234 v=1", wb.final_result, pipe.ms_to_ws_valid); end
    step();
    pipe.data_data_ok = 1'b0;
  endtask

  // random loads: random response latency and random writeback stall after data_ok
  task automatic test_load_random();
    es_to_ms_t   b;
    logic [31:0] rd, exp;
    int          dly, stall;
    for (int n = 0; n < 12; n++) begin
      rd    = $urandom;
      b     = ld_op(32'h1c00_1000 + 32'(n * 4), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      exp   = exp_load(rd, b.exe_result[1:0], b.mem_size, b.mem_sign_exted);
      dly   = $urandom_range(0, 3);
      stall = $urandom_range(0, 2);
      issue(b);
      for (int c = 0; c < dly; c++) begin
        pipe.data_rdata = $urandom;
        @(negedge clk);
        checks++; if (pipe.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL ldr_wait n=%0d got=%b exp=0", n, pipe.ms_to_ws_valid); end
        step();
      end
      pipe.data_data_ok = 1'b1;
      pipe.data_rdata   = rd;
      pipe.ws_allowin   = (stall == 0);
      @(negedge clk);
      checks++; if (pipe.ms_to_ws_valid !== 1'b1 || wb.final_result !== exp) begin failures++; $display("FAIL ldr_ok n=%0d got=%h v=%b exp=%h v=1", n, wb.final_result, pipe.ms_to_ws_valid, exp); end
      step();
      for (int k = 1; k <= stall; k++) begin
        pipe.data_data_ok = 1'b0;
        pipe.data_rdata   = $urandom;
        pipe.ws_allowin   = (k == stall);
        @(negedge clk);
        checks++; if (pipe.ms_to_ws_valid !== 1'b1 || wb.final_result !== exp) begin failures++; $display("FAIL ldr_hold n=%0d got=%h v=%b exp=%h v=1", n, wb.final_result, pipe.ms_to_ws_valid, exp); end
        step();
      end
      pipe.data_data_ok = 1'b0;
      pipe.ws_allowin   = 1'b1;
      @(negedge clk);
      checks++; if (ms_to_ds_valid !== 1'b0) begin failures++; $display("FAIL ldr_drain n=%0d got=%b exp=0", n, ms_to_ds_valid); end
      step();
    end
  endtask

  task automatic test_discard();
    es_to_ms_t b;
    b = ld_op(32'h1c00_0300, 2'b00, MEM_SIZE_WORD, 1'b0);
    issue(b);
    step();
    excp_flush = 1'b1;
    step();
    excp_flush = 1'b0;
    @(negedge clk);
    checks++; if (ms_to_ds_valid !== 1'b0) begin failures++; $display("FAIL disc_flushed got=%b exp=0", ms_to_ds_valid); end
    step();
    b = ld_op(32'h1c00_0304, 2'b00, MEM_SIZE_WORD, 1'b0);
    issue(b);
    pipe.data_data_ok = 1'b1;
    pipe.data_rdata   = 32'h0000_DEAD;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL disc_drop got=%b exp=0", pipe.ms_to_ws_valid); end
    step();
    pipe.data_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b1 || wb.final_result !== 32'h1234_5678 || wb.pc !== b.pc) begin failures++; $display("FAIL disc_second got=%h v=%b pc=%h exp=12345678 v=1 pc=%h", wb.final_result, pipe.ms_to_ws_valid, wb.pc, b.pc); end
    step();
    pipe.data_data_ok = 1'b0;
    // flush coinciding with data_ok leaves nothing in flight
    b = ld_op(32'h1c00_0308, 2'b00, MEM_SIZE_WORD, 1'b0);
    issue(b);
    refetch_flush     = 1'b1;
    pipe.data_data_ok = 1'b1;
    step();
    refetch_flush     = 1'b0;
    pipe.data_data_ok = 1'b0;
    b = ld_op(32'h1c00_030c, 2'b00, MEM_SIZE_WORD, 1'b0);
    issue(b);
    pipe.data_data_ok = 1'b1;
    pipe.data_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b1 || wb.final_result !== 32'hCAFE_F00D) begin failures++; $display("FAIL disc_same_cycle got=%h v=%b exp=cafef00d v=1", wb.final_result, pipe.ms_to_ws_valid); end
    step();
    pipe.data_data_ok = 1'b0;
  endtask

  task automatic test_flush_sources();
    es_to_ms_t b;
    for (int f = 0; f < 5; f++) begin
      pipe.ws_allowin = 1'b0;
      b = alu_op(32'h1c00_0400 + 32'(f * 4));
      issue(b);
      excp_flush    = (f == 0);
      ertn_flush    = (f == 1);
      refetch_flush = (f == 2);
      icacop_flush  = (f == 3);
      idle_flush    = (f == 4);
      step();
      {excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush} = 5'b0;
      @(negedge clk);
      checks++; if (ms_to_ds_valid !== 1'b0) begin failures++; $display("FAIL flush_src f=%0d got=%b exp=0", f, ms_to_ds_valid); end
      step();
    end
    pipe.ws_allowin = 1'b1;
  endtask

  task automatic test_result_select();
    es_to_ms_t   b;
    logic [31:0] exp;
    b = alu_op(32'h1c00_0500);
    b.mul_div_op = 4'b0010;
    mul_result   = 64'h0000_0003_0000_0001;
    issue(b);
    @(negedge clk);
    checks++; if (wb.final_result !== 32'h3) begin failures++; $display("FAIL mulh_w got=%h exp=3", wb.final_result); end
    b.mul_div_op = 4'b0001;
    issue(b);
    @(negedge clk);
    checks++; if (wb.final_result !== 32'h1) begin failures++; $display("FAIL mul_w got=%h exp=1", wb.final_result); end
    for (int n = 0; n < 16; n++) begin
      b            = alu_op(32'h1c00_0600 + 32'(n * 4));
      b.mul_div_op = 4'($urandom_range(0, 15));
      b.sc_w       = ($urandom_range(0, 3) == 0);
      b.gr_we      = 1'($urandom_range(0, 1));
      mul_result   = {$urandom, $urandom};
      div_result   = $urandom;
      mod_result   = $urandom;
      llbit        = 1'($urandom_range(0, 1));
      exp          = exp_result(b, 32'h0, mul_result, div_result, mod_result, llbit);
      issue(b);
      @(negedge clk);
      checks++; if (pipe.ms_to_ws_valid !== 1'b1 || wb.final_result !== exp) begin failures++; $display("FAIL rsel n=%0d op=%b sc=%b got=%h exp=%h", n, b.mul_div_op, b.sc_w, wb.final_result, exp); end
      checks++; if (fwd_en !== b.gr_we || fwd_stall !== 1'b0) begin failures++; $display("FAIL rsel_fwd n=%0d got=%b/%b exp=%b/0", n, fwd_en, fwd_stall, b.gr_we); end
    end
    b      = alu_op(32'h1c00_0700);
    b.dest = 5'd0;
    issue(b);
    @(negedge clk);
    checks++; if (fwd_en !== 1'b0) begin failures++; $display("FAIL fwd_dest0 got=%b exp=0", fwd_en); end
    step();
  endtask

  task automatic test_hazards();
    es_to_ms_t b;
    logic      exp_eh;
    pipe.ws_allowin = 1'b0;
    b = alu_op(32'h1c00_0800);
    b.csr_we  = 1'b1;
    b.csr_idx = CSR_TLBEHI;
    issue(b);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (ms_wr_tlbehi !== 1'b1 || ms_flush !== 1'b1) begin failures++; $display("FAIL tlbehi_hold cyc=%0d got=%b/%b exp=1/1", c, ms_wr_tlbehi, ms_flush); end
      checks++; if (pipe.ms_allowin !== 1'b0) begin failures++; $display("FAIL tlbehi_allowin cyc=%0d got=%b exp=0", c, pipe.ms_allowin); end
      step();
    end
    pipe.ws_allowin = 1'b1;
    step();
    @(negedge clk);
    checks++; if (ms_wr_tlbehi !== 1'b0 || ms_flush !== 1'b0) begin failures++; $display("FAIL tlbehi_gone got=%b/%b exp=0/0", ms_wr_tlbehi, ms_flush); end
    // each side-effect field alone
    for (int k = 0; k < 10; k++) begin
      b = alu_op(32'h1c00_0900 + 32'(k * 4));
      case (k)
        0: b.excp    = 1'b1;
        1: b.ertn    = 1'b1;
        2: begin b.csr_we = 1'b1; b.csr_idx = 14'h000; end
        3: b.refetch = 1'b1;
        4: b.tlbsrch = 1'b1;
        5: b.tlbwr   = 1'b1;
        6: b.tlbfill = 1'b1;
        7: b.tlbrd   = 1'b1;
        8: b.invtlb  = 1'b1;
        default: b.idle = 1'b1;
      endcase
      exp_eh = (k == 7);
      issue(b);
      @(negedge clk);
      checks++; if (ms_flush !== 1'b1 || ms_wr_tlbehi !== exp_eh) begin failures++; $display("FAIL hazard k=%0d got=%b/%b exp=1/%b", k, ms_flush, ms_wr_tlbehi, exp_eh); end
    end
    step();
  endtask

  task automatic test_excp_load();
    es_to_ms_t b;
    for (int n = 0; n < 2; n++) begin
      b          = ld_op(32'h1c00_0a00 + 32'(n * 4), 2'b01, MEM_SIZE_WORD, 1'b0);
      b.load_op  = (n == 0);
      b.store_op = (n == 1);
      b.excp     = 1'b1;
      b.excp_num = 10'($urandom);
      b.error_va = $urandom;
      issue(b);
      @(negedge clk);
      checks++; if (pipe.ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL excp_nowait n=%0d got=%b exp=1", n, pipe.ms_to_ws_valid); end
      checks++; if (wb.excp !== 1'b1 || wb.excp_num !== b.excp_num || wb.error_va !== b.error_va) begin failures++; $display("FAIL excp_pass n=%0d got=%b/%h/%h exp=1/%h/%h", n, wb.excp, wb.excp_num, wb.error_va, b.excp_num, b.error_va); end
      step();
      @(negedge clk);
      checks++; if (ms_to_ds_valid !== 1'b0) begin failures++; $display("FAIL excp_left n=%0d got=%b exp=0", n, ms_to_ds_valid); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    es_to_ms_t   b [4];
    for (int i = 0; i < 4; i++) b[i] = alu_op(32'h1c00_0b00 + 32'(i * 4));
    for (int i = 0; i <= 4; i++) begin
      pipe.es_to_ms_valid = (i < 4);
      if (i < 4) pipe.es_to_ms_bus = b[i];
      if (i > 0) begin
        @(negedge clk);
        checks++; if (pipe.ms_to_ws_valid !== 1'b1 || wb.pc !== b[i-1].pc || wb.final_result !== b[i-1].exe_result) begin failures++; $display("FAIL b2b i=%0d got=%h/%h exp=%h/%h", i, wb.pc, wb.final_result, b[i-1].pc, b[i-1].exe_result); end
      end
      step();
    end
    pipe.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (pipe.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", pipe.ms_to_ws_valid); end
    step();
  endtask

  initial begin
    reset               = 1'b1;
    pipe.es_to_ms_valid = 1'b0;
    pipe.es_to_ms_bus   = '0;
    pipe.ws_allowin     = 1'b1;
    pipe.data_data_ok   = 1'b0;
    pipe.data_rdata     = '0;
    mul_result          = '0;
    div_result          = '0;
    mod_result          = '0;
    llbit               = 1'b0;
    {excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush} = 5'b0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_load_random();
    test_discard();
    test_flush_sources();
    test_result_select();
    test_hazards();
    test_excp_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Registers the execute-to-memory bus and waits for the data-cache data_ok response of loads/stores issued in execute.
- Aligns and extends load data and selects the multiply/divide result.
- Produces the writeback bus, the decode forward bus, and the flush/TLBEHI hazard signals consumed by execute.

Parameters:
ES_TO_MS_WD, 215, execute-to-memory bus width; field layout per shared package
MS_TO_WS_WD, 168, memory-to-writeback bus width
FWD_WD, 39, forward bus width {dep_need_stall, forward_enable, dest[4:0], result[31:0]}

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_allowin  in  1  writeback can accept
ms_allowin  out  1  this stage can accept
es_to_ms_valid  in  1  execute bus valid
es_to_ms_bus  in  ES_TO_MS_WD  execute payload
ms_to_ws_valid  out  1  writeback bus valid
ms_to_ws_bus  out  MS_TO_WS_WD  {idle, tlb flags[6], error_va, csr_result, csr_idx, csr_we, ertn, excp_num, excp, gr_we, dest, final_result, pc}
ms_to_ds_forward_bus  out  FWD_WD  bypass to decode
ms_to_ds_valid  out  1  stage holds valid instruction
data_data_ok  in  1  dcache response strobe
data_rdata  in  32  dcache read data
mul_result  in  64  multiplier product
div_result  in  32  quotient
mod_result  in  32  remainder
llbit  in  1  current LLbit for sc.w
excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush  in  1 each  pipeline flushes
ms_flush  out  1  side-effect instruction present; blocks younger dcache requests
ms_wr_tlbehi  out  1  TLBEHI write or tlbrd present; stalls tlbsrch

Behaviour:
- Reset: ms_valid=0, discard=0, bus register=0. Consequently ms_to_ws_valid=0, ms_flush=0, ms_wr_tlbehi=0, and forward_enable=0.
- Any flush (OR of the five): ms_valid<=0 on the next edge. Otherwise, when ms_allowin: ms_valid<=es_to_ms_valid, and the bus is latched on es_to_ms_valid&&ms_allowin.
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Data wait:
  - need_data = ms_valid && (load_op||store_op||dcacop||preld_inst) && !excp.
  - ms_ready_go = !need_data || (data_data_ok && !discard).
  - data_ok is consumed once per instruction. Latency is 0 cycles after data_ok, or 1 cycle minimum from latch.
- Discard:
  - Flush while need_data && data_ok not yet seen, i.e. a request outstanding: discard<=1.
  - Next data_data_ok clears discard and is ignored.
  - A new instruction entering while discard=1 waits for a second data_ok.
  - Flush and data_ok in the same cycle: discard stays 0.
- Load extraction, offset = exe_result[1:0]:
  - Byte (mem_size=01): data_rdata[8*offset+:8].
  - Half (mem_size=10): offset[1] selects the upper half.
  - Word (mem_size=00): data_rdata unchanged.
  - Sign-extend when mem_sign_exted=1, else zero-extend.
- Result select, priority order:
  1. load → extracted data.
  2. sc_w → {31'b0, llbit}.
  3. mul_div_op[0] → mul_result[31:0].
  4. mul_div_op[1] → mul_result[63:32].
  5. mul_div_op[2] → div_result.
  6. mul_div_op[3] → mod_result.
  7. otherwise → exe_result.
- Forwarding:
  - forward_enable = gr_we && dest!=0 && ms_valid.
  - dep_need_stall = load_op && !ms_to_ws_valid.
- Hazard outputs:
  - ms_flush = ms_valid && (excp || ertn || csr_we || refetch || tlbsrch/wr/fill/rd || invtlb || idle).
  - ms_wr_tlbehi = ms_valid && ((csr_we && csr_idx==CSR_TLBEHI) || tlbrd).
- Exceptions pass through unchanged. A store with excp=1 never waits.

Optional Feature:
- Macro: MS_LOAD_FORWARD_EN.
- Defined: dep_need_stall = load_op && !ms_to_ws_valid, so the load result is forwarded in the data_ok cycle.
- Undefined: dep_need_stall = load_op && ms_valid for the whole residency, so decode waits until the load reaches writeback.

Decomposition:
- Shared package holds:
  - bus widths and field bit-offsets (ES_TO_MS, MS_TO_WS, FWD);
  - mem_size encodings;
  - mul_div_op bit indices;
  - CSR_TLBEHI index.
- One sub-module, mem_load_align: combinational rdata/offset/size/sign → 32-bit load value.

Test Plan:
- ld.b, addr low2=2'b11, rdata=32'h80_00_00_00, sign=1; data_ok after 3 cycles → result 32'hFFFF_FF80; ms_to_ws_valid only in the data_ok cycle.
- ld.hu, low2=2'b10, rdata=32'hBEEF_1234 → 32'h0000_BEEF; ld.h, low2=00 → 32'h0000_1234.
- Load outstanding, then excp_flush; a new ld.w enters; the first data_ok (rdata=32'hDEAD) is dropped; the second (32'h1234_5678) is written back.
- mulh.w with mul_result=64'h0000_0003_0000_0001 → final_result 32'h3; mul.w → 32'h1.
- csr write to TLBEHI in MS → ms_wr_tlbehi=1, ms_flush=1; ws_allowin=0 holds both for 2 cycles.
- Load with excp=1 (ALE) → ready_go immediately, no data_ok needed, excp_num passed unchanged.
